// File: rtl/md_pos_pkg.sv
// Shared types and constants for the position-cell reader.
package md_pos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_REQ,
    CNT_WAIT,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Cycles from an address being presented to its data on cell_q.
  localparam int RAM_RD_LAT = 2;

  // Field layout of a RAM word: {posz, posy, posx}.
  localparam int COORD_W  = 32;
  localparam int POSX_LSB = 0;
  localparam int POSY_LSB = 32;
  localparam int POSZ_LSB = 64;

endpackage

// File: rtl/pos_stream_fifo.sv
// Small synchronous FIFO carrying {last, pid, data} beats, with occupancy.
module pos_stream_fifo #(
  parameter int          WIDTH = 105,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so outputs read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && occupancy == OW'(DEPTH)));

endmodule

// File: rtl/pos_cell_reader.sv
// Drains one cell position RAM into a ready/valid particle stream.
module pos_cell_reader
  import md_pos_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] cell_address,
  output logic                  cell_rden,
  output logic                  cell_wren,
  input  logic [DATA_WIDTH-1:0] cell_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  state_t                state, state_next;
  logic [1:0]            wait_cnt;
  logic                  data_rden;
  logic [1:0]            pipe_vld;
  logic [ADDR_WIDTH-1:0] pipe_addr0, pipe_addr1;
  logic                  issue, capture, cnt_over, can_issue, push, pop;
  logic [ADDR_WIDTH-1:0] raw_count, clamped_count, issue_addr;
  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W:0]        occ_next;
  logic [OCC_W+1:0]      demand;
  logic [ENTRY_W-1:0]    push_entry, head_entry;

  assign cell_wren     = 1'b0;
  assign raw_count     = cell_q[ADDR_WIDTH-1:0];
  assign cnt_over      = raw_count > MAX_COUNT;
  assign clamped_count = cnt_over ? MAX_COUNT : raw_count;

  assign out_valid = occupancy != '0;
  assign pop       = out_valid & out_ready;
  assign push      = pipe_vld[1];
  assign push_entry = {pipe_addr1 == particle_count, pipe_addr1, cell_q};
  assign {out_last, out_pid, out_data} = head_entry;

  // Reads are decided one cycle ahead (cell_rden is a flop), so the credit check
  // uses next-cycle occupancy plus every read that will still be outstanding.
  assign occ_next  = {1'b0, occupancy} + {{OCC_W{1'b0}}, push} - {{OCC_W{1'b0}}, pop};
  assign demand    = {1'b0, occ_next} + {{(OCC_W+1){1'b0}}, data_rden}
                   + {{(OCC_W+1){1'b0}}, pipe_vld[0]};
  assign can_issue = demand < (OCC_W+2)'(FIFO_DEPTH);

  // Next-state, read-issue and count-capture decisions.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_addr = cell_address + ADDR_WIDTH'(1);
    capture    = 1'b0;
    case (state)
      IDLE:     if (start) state_next = CNT_REQ;
      CNT_REQ:  state_next = CNT_WAIT;
      CNT_WAIT: begin
        if (wait_cnt == 2'(RAM_RD_LAT - 1)) begin
          capture = 1'b1;
          if (clamped_count != '0) begin
            state_next = STREAM;
            issue      = 1'b1;
            issue_addr = ADDR_WIDTH'(1);
          end else begin
            state_next = DONE;
          end
        end
      end
      STREAM: begin
        if (cell_address == particle_count) state_next = DRAIN;
        else if (can_issue)                 issue      = 1'b1;
      end
      DRAIN: begin
        if (!data_rden && !pipe_vld[0] && occ_next == '0) state_next = DONE;
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      count_err      <= 1'b0;
      particle_count <= '0;
      cell_rden      <= 1'b0;
      data_rden      <= 1'b0;
      cell_address   <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= (state == CNT_WAIT) ? wait_cnt + 2'd1 : '0;
      busy      <= state_next != IDLE;
      done      <= state_next == DONE;
      count_err <= capture & cnt_over;
      if (capture) particle_count <= clamped_count;
      cell_rden <= issue | (state_next == CNT_REQ);
      data_rden <= issue;
      if (state_next == CNT_REQ) cell_address <= '0;
      else if (issue)            cell_address <= issue_addr;
    end
  end

  // Valid/address pipe aligned to the RAM read latency; the count read is not tracked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld   <= '0;
      pipe_addr0 <= '0;
      pipe_addr1 <= '0;
    end else begin
      pipe_vld   <= {pipe_vld[0], data_rden};
      pipe_addr0 <= cell_address;
      pipe_addr1 <= pipe_addr0;
    end
  end

  pos_stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_pos_cell_reader.sv
// Scoreboard bench for pos_cell_reader with a 2-cycle-latency RAM model.
module tb_pos_cell_reader;
  import md_pos_pkg::*;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, count_err, cell_rden, cell_wren, out_valid, out_last;
  logic [AW-1:0] particle_count, cell_address, out_pid;
  logic [DW-1:0] cell_q, out_data;

  pos_cell_reader #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .PARTICLE_NUM (PN),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .count_err      (count_err),
    .particle_count (particle_count),
    .cell_address   (cell_address),
    .cell_rden      (cell_rden),
    .cell_wren      (cell_wren),
    .cell_q         (cell_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_pid        (out_pid),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  // RAM model: address in cycle k, data on cell_q in cycle k+2.
  logic [DW-1:0] ram [PN];
  logic [DW-1:0] ram_r1, ram_q;
  always @(posedge clk) begin
    ram_r1 <= cell_rden ? ram[cell_address] : '0;
    ram_q  <= ram_r1;
  end
  assign cell_q = ram_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] ram_word(input int a);
    logic [DW-1:0] w;
    w = '0;
    w[POSX_LSB +: COORD_W] = 32'(a * 7 + 32'h1000);
    w[POSY_LSB +: COORD_W] = 32'(a) ^ 32'hA5A5_0000;
    w[POSZ_LSB +: COORD_W] = 32'hC0DE_0000 + 32'(a);
    return w;
  endfunction

  function automatic logic [DW+AW:0] beat(input int p, input int n);
    return {(p == n), AW'(p), ram_word(p)};
  endfunction

  logic [DW+AW:0] exp_q [$];
  int beats = 0, err_pulses = 0, done_pulses = 0, done_cyc = -1, first_valid_cyc = -1;
  logic [DW+AW:0] e;

  // Monitor: every valid cycle must show the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (count_err) err_pulses++;
      if (done) begin
        done_pulses++;
        done_cyc = cyc;
      end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got pid=%0d last=%0b data=%h required no beat", out_pid, out_last, out_data);
        end else begin
          e = exp_q[0];
          if ({out_last, out_pid, out_data} !== e) begin
            errors++;
            $display("FAIL beat got last=%0b pid=%0d data=%h required last=%0b pid=%0d data=%h",
                     out_last, out_pid, out_data, e[DW+AW], e[DW+AW-1:DW], e[DW-1:0]);
          end
        end
        if (out_ready) begin
          beats++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count_err"}, count_err, 0);
    check({tag, "_rden"}, cell_rden, 0);
    check({tag, "_wren"}, cell_wren, 0);
    check({tag, "_address"}, cell_address, 0);
    check({tag, "_particle_count"}, particle_count, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_pid"}, out_pid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data_zero"}, longint'(out_data == '0), 1);
  endtask

  task automatic run_seq(input logic [AW-1:0] cw, input int nexp, input int stall, input bit poke);
    int n, reads;
    bit finished;
    ram[0] = {88'hDEAD_BEEF_0000_1234_5678_AB, cw};
    exp_q.delete();
    for (int p = 1; p <= nexp; p++) exp_q.push_back(beat(p, nexp));
    err_pulses = 0; done_pulses = 0; done_cyc = -1; first_valid_cyc = -1; beats = 0; reads = 0;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    finished = 1'b0;
    for (int i = 0; i < 1000 && !finished; i++) begin
      @(posedge clk); #1;
      if (stall > 0 && cyc - n < stall && cell_rden && cell_address != '0) reads++;
      if (stall > 0 && cyc - n == stall) out_ready = 1'b1;
      start = poke && (cyc - n == 6);
      if (done_pulses > 0) finished = 1'b1;
    end
    start = 1'b0;
    check("done_seen", finished, 1);
    repeat (4) @(posedge clk);
    #1;
    check("done_pulses", done_pulses, 1);
    if (stall == 0) check("done_latency", done_cyc - n, (nexp == 0) ? 4 : nexp + 7);
    if (stall == 0 && nexp > 0) check("first_valid_latency", first_valid_cyc - n, 7);
    if (nexp == 0) check("no_valid", first_valid_cyc, -1);
    if (stall > 0) check("stall_reads_bounded", longint'(reads >= 1 && reads <= FD), 1);
    check("particle_count", particle_count, nexp);
    check("count_err_pulses", err_pulses, (cw > AW'(PN - 1)) ? 1 : 0);
    check("beats_received", beats, nexp);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    for (int a = 0; a < PN; a++) ram[a] = ram_word(a);
    #12;
    check_outputs_zero("reset");
    #11;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_seq(8'd5, 5, 0, 1'b0);     // basic stream, garbage upper bits in count word
    run_seq(8'd0, 0, 0, 1'b0);     // empty cell
    run_seq(8'd8, 8, 10, 1'b0);    // backpressure for 10 cycles
    run_seq(8'd250, 219, 0, 1'b0); // count clamped to PARTICLE_NUM-1
    run_seq(8'd6, 6, 0, 1'b1);     // start pulsed during STREAM

    // Reset while beat 3 of 10 is presented.
    ram[0] = {88'h0, 8'd10};
    exp_q.delete();
    for (int p = 1; p <= 10; p++) exp_q.push_back(beat(p, 10));
    beats = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (i = 0; i < 100 && beats < 2; i++) begin
      @(posedge clk); #1;
    end
    check("reached_beat3", longint'(beats == 2), 1);
    check("beat3_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_seq(8'd10, 10, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pos_cell_reader.md
# pos_cell_reader

Sequencer that drains one position cell memory (the `cell_X_Y_Z` single-port RAM) into a ready/valid particle stream for the force-evaluation pipeline.
- On `start`, it reads the particle count at address 0, then reads addresses 1..count, absorbing the RAM's fixed 2-cycle read latency.
- A credit-limited output FIFO decouples the RAM from downstream backpressure.
- It sits between the cell RAM and the pair-filter/force pipeline input, one instance per cell memory.

## Interface
Parameters:
- `DATA_WIDTH`, 96: RAM word width, packed `{posz, posy, posx}`.
- `ADDR_WIDTH`, 8: RAM address width.
- `PARTICLE_NUM`, 220: RAM depth. Maximum legal count is `PARTICLE_NUM-1`.
- `FIFO_DEPTH`, 4: output FIFO entries. Must be ≥ 3.

Ports:
- `clk`  in  1  single clock for all logic and the RAM.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to read the cell. Accepted only in IDLE; ignored otherwise.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` pulses, inclusive.
- `done`  out  1  one-cycle pulse when the read sequence completes.
- `count_err`  out  1  one-cycle pulse when the stored count exceeds `PARTICLE_NUM-1`.
- `particle_count`  out  ADDR_WIDTH  count latched from address 0, after clamping.
- `cell_address`  out  ADDR_WIDTH  RAM address.
- `cell_rden`  out  1  RAM read enable.
- `cell_wren`  out  1  tied to 0.
- `cell_q`  in  DATA_WIDTH  RAM read data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_data`  out  DATA_WIDTH  particle position.
- `out_pid`  out  ADDR_WIDTH  particle index, 1-based (equals its RAM address).
- `out_last`  out  1  marks the beat whose `out_pid == particle_count`.

## Operation
- States:
  - IDLE → CNT_REQ on `start`.
  - CNT_REQ (`cell_rden=1`, `cell_address=0`) → CNT_WAIT.
  - CNT_WAIT (2 cycles) → STREAM if count > 0, else DONE.
  - STREAM → DRAIN after the read of address `count` is issued.
  - DRAIN → DONE when nothing is in flight, the FIFO is empty and no beat is pending.
  - DONE (`done=1`) → IDLE.
- Count capture:
  - The count is taken from `cell_q[ADDR_WIDTH-1:0]` at the end of the second CNT_WAIT cycle.
  - If the value exceeds `PARTICLE_NUM-1`, it is clamped to `PARTICLE_NUM-1` and `count_err` pulses in that same cycle.
  - Upper bits of the count word are ignored.
- Read issue in STREAM:
  - A read is issued (`cell_rden=1`, next address) only when `fifo_occupancy + inflight < FIFO_DEPTH`.
  - `inflight` is at most 2, tracked by a 2-stage valid shift register aligned to the RAM latency.
  - Returning data is pushed into the FIFO together with its address as `out_pid`.
  - The FIFO never overflows. Hitting an overflow is an assertion failure.
- Outputs:
  - `out_valid` is high whenever the FIFO is non-empty.
  - A beat transfers on `out_valid & out_ready`.
  - `out_data`, `out_pid` and `out_last` hold stable while `out_valid & !out_ready`.
- Address counter: ADDR_WIDTH bits, no wrap. The highest address issued is `particle_count`.
- `start` while `busy` is ignored and has no side effects.
- Reset, including mid-stream:
  - All outputs go to 0.
  - The FSM returns to IDLE, the FIFO and in-flight pipe are flushed, and `particle_count` goes to 0.
  - RAM data returning after reset is discarded.

## Timing
- Cycle n: `start=1` in IDLE.
- n+1: CNT_REQ.
- n+2, n+3: CNT_WAIT. The count is latched at the end of n+3.
- n+4: read of address 1.
- n+6: its data reaches the FIFO.
- n+7: first `out_valid`.
- With `out_ready` held high, throughput is 1 beat/cycle.
- `done` pulses 1 cycle after the handshake of the `out_last` beat.
- Count = 0: `done` pulses at n+4 with no beats.
- Total cycles from start to done, with ready always high: count + 7 for count ≥ 1.
- All outputs are registered; there is no combinational path from `out_ready` to `cell_rden`.

## Structure
- Package `md_pos_pkg` holds:
  - the state enum (IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, DONE);
  - `RAM_RD_LAT = 2`;
  - the `{posz, posy, posx}` field offsets.
- Sub-module `pos_stream_fifo`: synchronous FIFO of width DATA_WIDTH+ADDR_WIDTH+1 and depth FIFO_DEPTH, with occupancy output and asynchronous active-low reset.

## Test plan
- Count word = 5, ready always high:
  - beats carry pid 1..5 with addr-1..5 data on consecutive cycles from n+7;
  - `out_last` on pid 5;
  - `done` at n+12.
- Count = 0: no `out_valid`, `done` at n+4, `particle_count` = 0.
- Count = 8 with ready low 10 cycles then high:
  - at most FIFO_DEPTH reads issued before ready rises;
  - data is held stable while stalled;
  - all 8 beats arrive in order with none lost.
- Count word = 250 with PARTICLE_NUM = 220: `count_err` pulses once and exactly 219 beats arrive.
- `start` pulsed during STREAM: no effect, sequence unchanged.
- `rst_n` low during beat 3 of 10:
  - all outputs 0 immediately;
  - after release, a new `start` yields a clean sequence from pid 1 with no stale beats.
